sr_cmd_conditioner: RTL

- Upstream command stage for the negedge-clocked SR flip-flop (sr_ff).
- Turns two raw, asynchronous, bouncy request lines (set_req, clr_req) into clean, spaced, mutually exclusive one-shot s/r commands.
- Resolves simultaneous set/clear conflicts by a fixed priority policy and keeps a shadow copy of the expected flop state.
- s/r are registered on the rising edge of clk, so they are stable at the consumer's falling-edge sample.

---
 rtl/sr_cmd_conditioner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sr_cmd_conditioner.sv
// rtl/sr_cmd_conditioner.sv - debounced, spaced, mutually exclusive s/r command generator for sr_ff
//
// Purpose: turns two raw asynchronous request levels into clean one-shot set/reset
// commands. Each request is synchronised, debounced and edge-detected, then latched
// as pending. A small IDLE/ISSUE/HOLD machine issues one command at a time, and a
// fixed priority policy resolves simultaneous requests.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   set_req      raw set request level (asynchronous)
//   clr_req      raw clear request level (asynchronous)
//   s, r         registered one-shot commands, never both high
//   busy         machine not idle or a request is pending
//   q_shadow     expected sr_ff state after the last issued command
//   conflict_cnt saturating count of set/clear conflicts
module sr_cmd_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int PULSE_W  = 1,
    parameter int HOLDOFF  = 2,
    parameter int PRIORITY = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_req,
    input  logic             clr_req,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             q_shadow,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int T_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [T_W-1:0]  PW_LAST = T_W'(PULSE_W - 1);
    localparam logic [T_W-1:0]  HO_LAST = T_W'(HOLDOFF - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] dcnt_q [2];
    logic [DB_W-1:0] dcnt_d [2];
    logic [1:0]      pend_q, pend_d, take;
    logic [1:0]      rise;
    logic [1:0]      state_q, state_d;
    logic [T_W-1:0]  tmr_q, tmr_d;
    logic            s_q, s_d, r_q, r_d;
    logic            qsh_q, qsh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: a level change is accepted only after DEBOUNCE consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            deb_d[ch]  = deb_q[ch];
            dcnt_d[ch] = '0;
            if (sync2_q[ch] != deb_q[ch]) begin
                if (dcnt_q[ch] == DB_LAST) begin
                    deb_d[ch] = ~deb_q[ch];
                end else begin
                    dcnt_d[ch] = dcnt_q[ch] + DB_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        s_d     = s_q;
        r_d     = r_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        take    = 2'b00;
        case (state_q)
            IDLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                tmr_d = '0;
                if (pend_q == 2'b11) begin
                    take = 2'b11;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (PRIORITY == 1) begin
                        s_d     = 1'b1;
                        state_d = ISSUE;
                    end else if (PRIORITY == 2) begin
                        r_d     = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (pend_q[0]) begin
                    take    = 2'b01;
                    s_d     = 1'b1;
                    state_d = ISSUE;
                end else if (pend_q[1]) begin
                    take    = 2'b10;
                    r_d     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tmr_q == PW_LAST) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    tmr_d   = '0;
                    state_d = (HOLDOFF == 0) ? IDLE : HOLD;
                end else begin
                    tmr_d = tmr_q + T_W'(1);
                end
            end
            HOLD: begin
                if (tmr_q == HO_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + T_W'(1);
                end
            end
            default: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                tmr_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (s_d) begin
            qsh_d = 1'b1;
        end else if (r_d) begin
            qsh_d = 1'b0;
        end
        // A fresh edge on a channel being consumed this cycle re-arms it.
        pend_d = (pend_q & ~take) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '{default: '0};
            pend_q     <= '0;
            state_q    <= IDLE;
            tmr_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            qsh_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= {clr_req, set_req};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            qsh_q      <= qsh_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s            = s_q;
    assign r            = r_q;
    assign q_shadow     = qsh_q;
    assign conflict_cnt = cnt_q;
    assign busy         = (state_q != IDLE) | (|pend_q);

endmodule
